// File: rtl/clock_pkg.sv
// Shared types, reset defaults and BCD/calendar helpers for the clock-set front end.
//   field_e   : editable field codes, matching the field_sel output encoding
//   bcd_t     : one BCD digit
//   DEF_HMS   : shadow time after reset, 00:00:00
//   DEF_DATE  : shadow date after reset, 01-01-2024
//   max_day() : days in a month, two-digit-year leap rule (no century rule)
//   bcd2_*()  : two-digit BCD step with wrap between lo and hi
//   bcd4_*()  : four-digit BCD step with wrap 0000..9999
package clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [2:0] {
        FieldHour  = 3'd0,
        FieldMin   = 3'd1,
        FieldSec   = 3'd2,
        FieldDay   = 3'd3,
        FieldMonth = 3'd4,
        FieldYear  = 3'd5
    } field_e;

    localparam logic [23:0] DEF_HMS  = 24'h00_00_00;
    localparam logic [31:0] DEF_DATE = 32'h01_01_2024;

    // Returns the last valid day of the month as two BCD digits.
    function automatic logic [7:0] max_day(input bcd_t mo1, input bcd_t mo0,
                                           input bcd_t y1, input bcd_t y0);
        logic       leap;
        logic [7:0] mo;
        mo = {mo1, mo0};
        // 10*y1 + y0 divisible by 4: even tens need y0 in {0,4,8}, odd tens y0 in {2,6}.
        if (y1[0]) begin
            leap = (y0 == 4'd2) || (y0 == 4'd6);
        end else begin
            leap = (y0 == 4'd0) || (y0 == 4'd4) || (y0 == 4'd8);
        end
        case (mo)
            8'h02:                      max_day = leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: max_day = 8'h30;
            default:                    max_day = 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi);
        bcd_t tens;
        bcd_t ones;
        tens = v[7:4];
        ones = v[3:0];
        // Packed BCD orders like binary, so >= also catches out-of-range seeds.
        if (v >= hi) begin
            bcd2_inc = lo;
        end else if (ones >= 4'd9) begin
            bcd2_inc = {tens + 4'd1, 4'd0};
        end else begin
            bcd2_inc = {tens, ones + 4'd1};
        end
    endfunction

    function automatic logic [7:0] bcd2_dec(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi);
        bcd_t tens;
        bcd_t ones;
        tens = v[7:4];
        ones = v[3:0];
        if (v <= lo) begin
            bcd2_dec = hi;
        end else if (ones == 4'd0) begin
            bcd2_dec = {tens - 4'd1, 4'd9};
        end else begin
            bcd2_dec = {tens, ones - 4'd1};
        end
    endfunction

    function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        bcd4_inc = r;
    endfunction

    function automatic logic [15:0] bcd4_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        bcd4_dec = r;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Debouncer for one raw active-low push-button.
//   clk, rst_n : system clock, asynchronous active-low reset
//   raw_ni     : raw key level, 0 = pressed, asynchronous to clk
//   press_o    : one-cycle pulse when a press (1->0) is accepted
// A level is accepted after DEB_CYCLES consecutive synchronised samples differ from the
// current accepted level; raw edge to press_o takes 2 + DEB_CYCLES cycles.
module button_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned DEB_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_ni,
    output logic press_o
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             press_q;
    logic [DEB_W-1:0] cnt_q;
    logic             accept;

    assign accept  = (sync2_q != level_q) && (cnt_q == CNT_LAST);
    assign press_o = press_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= raw_ni;
            sync2_q <= sync1_q;
            // Release acceptance updates the level silently.
            press_q <= accept & ~sync2_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock/calendar set controller: debounces three keys and edits a shadow copy of
// time/date field by field, then commits it to the counter with a one-cycle load.
//   clk, rst_n        : 50 MHz clock, asynchronous active-low reset
//   tick_1s           : one-cycle pulse per second
//   butt_increase/decrease/change : raw active-low keys
//   cur_hms, cur_date : live BCD time {h1,h0,m1,m0,s1,s0} / date {d1,d0,mo1,mo0,y3..y0}
//   edit_active       : high in HOUR..YEAR
//   field_sel         : selected field (field_e), 0 when not editing
//   edit_hms/date     : shadow time/date
//   load              : one-cycle commit strobe
//   blink             : toggles per tick_1s while editing
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned DEB_W      = 20,
    parameter int unsigned TIMEOUT_S  = 10,
    parameter int unsigned TO_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1s,
    input  logic        butt_increase,
    input  logic        butt_decrease,
    input  logic        butt_change,
    input  logic [23:0] cur_hms,
    input  logic [31:0] cur_date,
    output logic        edit_active,
    output logic [2:0]  field_sel,
    output logic [23:0] edit_hms,
    output logic [31:0] edit_date,
    output logic        load,
    output logic        blink
);

    // Edit states share codes with field_e so field_sel is a direct copy.
    typedef enum logic [2:0] {
        StHour   = 3'd0,
        StMin    = 3'd1,
        StSec    = 3'd2,
        StDay    = 3'd3,
        StMonth  = 3'd4,
        StYear   = 3'd5,
        StIdle   = 3'd6,
        StCommit = 3'd7
    } state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);

    logic inc_ev, dec_ev, chg_ev;
    logic inc, dec, chg;

    state_e          state_q, state_d;
    logic [23:0]     hms_q, hms_d;
    logic [31:0]     date_q, date_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            edit_q, edit_d;
    logic            edit_active_q;
    field_e          field_sel_q;
    logic            load_q;
    logic            blink_q;

    logic [7:0]  md;
    logic [7:0]  mo_new;
    logic [15:0] yr_new;

    button_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_deb_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_ni  (butt_increase),
        .press_o (inc_ev)
    );

    button_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_deb_dec (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_ni  (butt_decrease),
        .press_o (dec_ev)
    );

    button_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_deb_chg (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_ni  (butt_change),
        .press_o (chg_ev)
    );

    assign edit_q = (state_q != StIdle) && (state_q != StCommit);
    assign edit_d = (state_d != StIdle) && (state_d != StCommit);

    always_comb begin
        // change wins; inc and dec together cancel.
        chg     = chg_ev;
        inc     = inc_ev & ~dec_ev & ~chg_ev;
        dec     = dec_ev & ~inc_ev & ~chg_ev;
        state_d = state_q;
        hms_d   = hms_q;
        date_d  = date_q;
        to_d    = to_q;
        md      = 8'h31;
        mo_new  = date_q[23:16];
        yr_new  = date_q[15:0];
        case (state_q)
            StIdle: begin
                if (chg) begin
                    state_d = StHour;
                    hms_d   = cur_hms;
                    date_d  = cur_date;
                    to_d    = '0;
                end
            end
            StCommit: state_d = StIdle;
            default: begin
                if (chg_ev || inc_ev || dec_ev) begin
                    to_d = '0;
                end else if (tick_1s) begin
                    if (to_q == TO_LAST) begin
                        to_d    = '0;
                        state_d = StIdle;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
                if (chg) begin
                    case (state_q)
                        StHour:  state_d = StMin;
                        StMin:   state_d = StSec;
                        StSec:   state_d = StDay;
                        StDay:   state_d = StMonth;
                        StMonth: state_d = StYear;
                        default: state_d = StCommit;
                    endcase
                end else if (inc || dec) begin
                    case (state_q)
                        StHour: hms_d[23:16] = inc ? bcd2_inc(hms_q[23:16], 8'h00, 8'h23)
                                                   : bcd2_dec(hms_q[23:16], 8'h00, 8'h23);
                        StMin:  hms_d[15:8]  = inc ? bcd2_inc(hms_q[15:8], 8'h00, 8'h59)
                                                   : bcd2_dec(hms_q[15:8], 8'h00, 8'h59);
                        StSec:  hms_d[7:0]   = inc ? bcd2_inc(hms_q[7:0], 8'h00, 8'h59)
                                                   : bcd2_dec(hms_q[7:0], 8'h00, 8'h59);
                        StDay: begin
                            md = max_day(date_q[23:20], date_q[19:16], date_q[7:4], date_q[3:0]);
                            date_d[31:24] = inc ? bcd2_inc(date_q[31:24], 8'h01, md)
                                                : bcd2_dec(date_q[31:24], 8'h01, md);
                        end
                        StMonth: begin
                            mo_new = inc ? bcd2_inc(date_q[23:16], 8'h01, 8'h12)
                                         : bcd2_dec(date_q[23:16], 8'h01, 8'h12);
                            md = max_day(mo_new[7:4], mo_new[3:0], date_q[7:4], date_q[3:0]);
                            date_d[23:16] = mo_new;
                            if (date_q[31:24] > md) begin
                                date_d[31:24] = md;
                            end
                        end
                        StYear: begin
                            yr_new = inc ? bcd4_inc(date_q[15:0]) : bcd4_dec(date_q[15:0]);
                            md = max_day(date_q[23:20], date_q[19:16], yr_new[7:4], yr_new[3:0]);
                            date_d[15:0] = yr_new;
                            if (date_q[31:24] > md) begin
                                date_d[31:24] = md;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            hms_q         <= DEF_HMS;
            date_q        <= DEF_DATE;
            to_q          <= '0;
            edit_active_q <= 1'b0;
            field_sel_q   <= FieldHour;
            load_q        <= 1'b0;
            blink_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hms_q         <= hms_d;
            date_q        <= date_d;
            to_q          <= to_d;
            edit_active_q <= edit_d;
            field_sel_q   <= edit_d ? field_e'(3'(state_d)) : FieldHour;
            load_q        <= (state_d == StCommit);
            if (!edit_d) begin
                blink_q <= 1'b0;
            end else if (tick_1s && edit_q) begin
                blink_q <= ~blink_q;
            end
        end
    end

    assign edit_active = edit_active_q;
    assign field_sel   = field_sel_q;
    assign edit_hms    = hms_q;
    assign edit_date   = date_q;
    assign load        = load_q;
    assign blink       = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with a short debounce window.
module tb_clock_set_ctrl;

    localparam int unsigned DEB = 8;

    localparam logic [2:0] K_DEC = 3'b001;
    localparam logic [2:0] K_INC = 3'b010;
    localparam logic [2:0] K_CHG = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_1s;
    logic        b_inc, b_dec, b_chg;
    logic [23:0] cur_hms;
    logic [31:0] cur_date;
    logic        edit_active;
    logic [2:0]  field_sel;
    logic [23:0] edit_hms;
    logic [31:0] edit_date;
    logic        load;
    logic        blink;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          load_cnt = 0;
    logic [23:0] cap_hms  = '0;
    logic [31:0] cap_date = '0;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .DEB_CYCLES (DEB),
        .DEB_W      (4),
        .TIMEOUT_S  (10),
        .TO_W       (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick_1s       (tick_1s),
        .butt_increase (b_inc),
        .butt_decrease (b_dec),
        .butt_change   (b_chg),
        .cur_hms       (cur_hms),
        .cur_date      (cur_date),
        .edit_active   (edit_active),
        .field_sel     (field_sel),
        .edit_hms      (edit_hms),
        .edit_date     (edit_date),
        .load          (load),
        .blink         (blink)
    );

    // Each sampled high cycle of load counts once and captures the committed values.
    always @(negedge clk) begin
        if (load === 1'b1) begin
            load_cnt = load_cnt + 1;
            cap_hms  = edit_hms;
            cap_date = edit_date;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold keys {chg,inc,dec} long enough to be accepted, then release and settle.
    task automatic press(input logic [2:0] m);
        b_chg = ~m[2];
        b_inc = ~m[1];
        b_dec = ~m[0];
        wait_neg(DEB + 4);
        b_chg = 1'b1;
        b_inc = 1'b1;
        b_dec = 1'b1;
        wait_neg(DEB + 4);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            tick_1s = 1'b1;
            @(negedge clk);
            tick_1s = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        tick_1s  = 1'b0;
        b_inc    = 1'b1;
        b_dec    = 1'b1;
        b_chg    = 1'b1;
        cur_hms  = 24'h23_59_58;
        cur_date = 32'h31_01_2023;
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(2);

        // Reset state
        chk("rst_active", 32'(edit_active), 32'd0);
        chk("rst_field",  32'(field_sel),   32'd0);
        chk("rst_load",   32'(load),        32'd0);
        chk("rst_blink",  32'(blink),       32'd0);
        chk("rst_hms",    32'(edit_hms),    32'h00_00_00);
        chk("rst_date",   edit_date,        32'h01_01_2024);

        // Glitch shorter than the debounce window
        b_chg = 1'b0;
        wait_neg(DEB - 5);
        b_chg = 1'b1;
        wait_neg(20);
        chk("glitch_active", 32'(edit_active), 32'd0);
        chk("glitch_field",  32'(field_sel),   32'd0);

        // inc ignored in IDLE
        press(K_INC);
        chk("idle_inc_hms", 32'(edit_hms), 32'h00_00_00);

        // Full pass: enter, edit every field, commit
        press(K_CHG);
        chk("enter_active", 32'(edit_active), 32'd1);
        chk("enter_field",  32'(field_sel),   32'd0);
        chk("enter_hms",    32'(edit_hms),    32'h23_59_58);
        chk("enter_date",   edit_date,        32'h31_01_2023);
        press(K_INC);
        chk("hour_inc_wrap", 32'(edit_hms), 32'h00_59_58);
        press(K_DEC);
        chk("hour_dec_wrap", 32'(edit_hms), 32'h23_59_58);
        press(K_DEC);
        chk("hour_dec", 32'(edit_hms), 32'h22_59_58);
        press(K_INC | K_DEC);
        chk("inc_dec_drop", 32'(edit_hms), 32'h22_59_58);
        press(K_CHG | K_INC);
        chk("chg_wins_field", 32'(field_sel), 32'd1);
        chk("chg_wins_hms",   32'(edit_hms),  32'h22_59_58);
        press(K_INC);
        chk("min_inc_wrap", 32'(edit_hms), 32'h22_00_58);
        press(K_CHG);
        chk("sec_field", 32'(field_sel), 32'd2);
        press(K_DEC);
        chk("sec_dec", 32'(edit_hms), 32'h22_00_57);
        press(K_CHG);
        chk("day_field", 32'(field_sel), 32'd3);
        press(K_INC);
        chk("day_inc_wrap", edit_date, 32'h01_01_2023);
        press(K_DEC);
        chk("day_dec_wrap", edit_date, 32'h31_01_2023);
        press(K_CHG);
        chk("month_field", 32'(field_sel), 32'd4);
        press(K_INC);
        chk("month_clamp_2023", edit_date, 32'h28_02_2023);
        press(K_CHG);
        chk("year_field", 32'(field_sel), 32'd5);
        press(K_INC);
        chk("year_inc", edit_date, 32'h28_02_2024);
        press(K_CHG);
        chk("commit_count",  load_cnt,             32'd1);
        chk("commit_hms",    32'(cap_hms),         32'h22_00_57);
        chk("commit_date",   cap_date,             32'h28_02_2024);
        chk("commit_active", 32'(edit_active),     32'd0);
        chk("commit_field",  32'(field_sel),       32'd0);
        chk("commit_load",   32'(load),            32'd0);

        // Leap-year February and year-change clamp
        cur_date = 32'h31_01_2024;
        press(K_CHG);
        repeat (4) press(K_CHG);
        chk("leap_month_field", 32'(field_sel), 32'd4);
        press(K_INC);
        chk("month_clamp_2024", edit_date, 32'h29_02_2024);
        press(K_CHG);
        press(K_INC);
        chk("year_clamp_2025", edit_date, 32'h28_02_2025);
        press(K_CHG);
        chk("commit2_count", load_cnt, 32'd2);
        chk("commit2_date",  cap_date, 32'h28_02_2025);

        // Four-digit year wrap
        cur_date = 32'h15_06_9999;
        press(K_CHG);
        repeat (5) press(K_CHG);
        chk("wrap_year_field", 32'(field_sel), 32'd5);
        press(K_INC);
        chk("year_9999_inc", edit_date, 32'h15_06_0000);
        press(K_DEC);
        chk("year_0000_dec", edit_date, 32'h15_06_9999);
        press(K_INC);
        chk("year_wrap_again", edit_date, 32'h15_06_0000);

        // Asynchronous reset mid-edit
        rst_n = 1'b0;
        #1;
        chk("midrst_active", 32'(edit_active), 32'd0);
        chk("midrst_field",  32'(field_sel),   32'd0);
        chk("midrst_load",   32'(load),        32'd0);
        chk("midrst_blink",  32'(blink),       32'd0);
        chk("midrst_hms",    32'(edit_hms),    32'h00_00_00);
        chk("midrst_date",   edit_date,        32'h01_01_2024);
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(2);
        chk("midrst_no_load", load_cnt, 32'd2);

        // Timeout in MIN after ten idle seconds
        cur_hms = 24'h10_20_30;
        press(K_CHG);
        press(K_CHG);
        chk("to_field", 32'(field_sel), 32'd1);
        tick(1);
        chk("blink_first", 32'(blink), 32'd1);
        tick(8);
        chk("to_9_active", 32'(edit_active), 32'd1);
        chk("to_9_field",  32'(field_sel),   32'd1);
        chk("to_9_blink",  32'(blink),       32'd1);
        tick(1);
        chk("to_10_active", 32'(edit_active), 32'd0);
        chk("to_10_field",  32'(field_sel),   32'd0);
        chk("to_10_blink",  32'(blink),       32'd0);
        chk("to_10_hms",    32'(edit_hms),    32'h10_20_30);
        wait_neg(3);
        chk("to_no_load",   load_cnt,         32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- User-input front end for the decade clock/calendar; the input-side counterpart to the counter's 7-segment output path.
- Debounces the three raw push-buttons and runs an edit FSM over a shadow copy of time/date.
- Field-select stepping, BCD increment/decrement with wrap and calendar clamping.
- Commits the edited value to the counter with a one-cycle load strobe.

Parameters:
DEB_CYCLES, 1_000_000, cycles a raw button level must be stable to be accepted (20 ms at 50 MHz)
DEB_W, 20, width of debounce counter
TIMEOUT_S, 10, tick_1s pulses without a press before edit aborts
TO_W, 4, width of timeout counter

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  reset; asynchronous, active-low
tick_1s  in  1  one-cycle pulse per second from the counter's divider
butt_increase  in  1  raw key, active-low (0 = pressed), asynchronous
butt_decrease  in  1  raw key, active-low, asynchronous
butt_change  in  1  raw key, active-low, asynchronous
cur_hms  in  24  live BCD time {h1,h0,m1,m0,s1,s0}
cur_date  in  32  live BCD date {d1,d0,mo1,mo0,y3,y2,y1,y0}
edit_active  out  1  high while in any edit state
field_sel  out  3  selected field: 0 HOUR, 1 MIN, 2 SEC, 3 DAY, 4 MONTH, 5 YEAR
edit_hms  out  24  shadow time, same packing as cur_hms
edit_date  out  32  shadow date, same packing as cur_date
load  out  1  one-cycle strobe; counter copies edit_hms/edit_date on it
blink  out  1  toggles on each tick_1s while edit_active, else 0

Behaviour:
- Reset values:
  - edit_active=0, field_sel=0, load=0, blink=0.
  - edit_hms=00:00:00, edit_date=01-01-2024.
  - Debouncers read "released"; FSM in IDLE.
- Debounce:
  - 2-FF synchroniser, then counter.
  - Accepted level changes after DEB_CYCLES consecutive equal samples.
  - Press event = one-cycle pulse on accepted 1->0 transition. Release generates nothing.
  - Raw-edge-to-event latency = 2 + DEB_CYCLES cycles.
- Event priority per cycle:
  - change beats inc/dec; a simultaneous inc/dec is dropped.
  - inc and dec together are both dropped.
- FSM states: IDLE, HOUR, MIN, SEC, DAY, MONTH, YEAR, COMMIT.
  - IDLE: inc/dec ignored. On change: shadow <= cur_hms/cur_date in that same cycle, go to HOUR.
  - HOUR..YEAR: change advances to the next state; change in YEAR goes to COMMIT.
  - COMMIT: load=1 for exactly this cycle, then IDLE unconditionally.
- Field update: applied to the shadow the cycle after the event (registered).
  - Hour: 00..23 wrap (23+1=00, 00-1=23).
  - Minute, second: 00..59 wrap.
  - Day: 01..maxday wrap, where maxday is taken from the shadow month/year.
  - Month: 01..12 wrap.
  - Year: 0000..9999 wrap, four-digit BCD carry/borrow.
  - All arithmetic is digit-wise BCD; no shadow digit ever exceeds 9.
- Calendar rules:
  - maxday = 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11.
  - February: 29 if the two low year digits form a value divisible by 4, else 28. No century rule.
  - A month or year change that leaves day > maxday clamps day to maxday in the same update cycle (31-03 dec month -> 28-02 on a non-leap year).
- Timeout:
  - Counter clears on any accepted event and on entering HOUR; increments on tick_1s in edit states.
  - Reaching TIMEOUT_S returns to IDLE with no load; the shadow is retained but stale.
- Outputs:
  - edit_active = state not IDLE and not COMMIT.
  - field_sel = state encoding in edit states, 0 otherwise.
  - blink clears when returning to IDLE.
- Reset mid-edit: immediate return to reset values; no load is issued.
- A held button produces a single event (no auto-repeat).

Decomposition:
- Package clock_pkg holds:
  - field_e enum with the six field values above.
  - bcd_t (4-bit digit).
  - Reset-default constants DEF_HMS and DEF_DATE.
  - Function max_day(mo1, mo0, y1, y0).
  - BCD inc/dec-with-wrap helper functions.
- One sub-module, button_debounce (synchroniser, counter, press pulse), instantiated three times.

Test Plan:
- Raw change low for DEB_CYCLES-5 cycles then high -> no event, FSM stays IDLE, edit_active=0.
- cur_hms=23:59:58; change, then inc in HOUR -> edit_hms hour=00; dec twice -> 22; minutes/seconds untouched.
- Shadow date 31-01-2023; change to MONTH, inc -> 28-02-2023. Same with year 2024 -> 29-02-2024.
- Shadow date 29-02-2024; in YEAR, inc -> 28-02-2025. Year 9999 inc -> 0000.
- Full pass: 6 change presses after entry -> load high for exactly one cycle carrying the shadow values, then IDLE.
- In MIN, apply 10 tick_1s with no press (TIMEOUT_S=10) -> IDLE, load never asserted. Separately, assert rst_n low mid-edit -> all outputs at reset values within the same cycle.
